// File: rtl/gate2_tester_if.sv
// ============================================================
// gate2_tester_if: handshake/result bundle between the gate
// BIST driver/checker and its environment.
// Rev 1.0
// ============================================================
`default_nettype none

interface gate2_tester_if;
  logic       start;
  logic       gate_out;
  logic       a;
  logic       b;
  logic       busy;
  logic       done;
  logic       pass;
  logic [3:0] fail_vec;
  logic [2:0] err_count;

  modport master (
    input  start, gate_out,
    output a, b, busy, done, pass, fail_vec, err_count
  );

  modport slave (
    output start, gate_out,
    input  a, b, busy, done, pass, fail_vec, err_count
  );
endinterface

`default_nettype wire

// File: rtl/gate2_tester.sv
// ============================================================
// gate2_tester: drives all four {a,b} vectors into a 2-input
// gate, checks each sample against EXPECT, reports the results.
// Rev 1.0
// ============================================================
`default_nettype none

module gate2_tester #(
  parameter int         SETTLE_CYCLES = 2,
  parameter logic [3:0] EXPECT        = 4'b1000
) (
  input  wire              clk,
  input  wire              rst,
  gate2_tester_if.master   bus
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETTLE = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  localparam logic [3:0] SETTLE_LAST = SETTLE_CYCLES[3:0];

  logic [1:0] state_q,     state_d;
  logic [1:0] idx_q,       idx_d;
  logic [3:0] cnt_q,       cnt_d;
  logic       a_q,         a_d;
  logic       b_q,         b_d;
  logic       busy_q,      busy_d;
  logic       done_q,      done_d;
  logic       pass_q,      pass_d;
  logic [3:0] fail_vec_q,  fail_vec_d;
  logic [2:0] err_count_q, err_count_d;
  logic       mismatch;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    a_d         = a_q;
    b_d         = b_q;
    busy_d      = busy_q;
    done_d      = done_q;
    pass_d      = pass_q;
    fail_vec_d  = fail_vec_q;
    err_count_d = err_count_q;
    mismatch    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d     = S_SETTLE;
          idx_d       = 2'd0;
          cnt_d       = 4'd0;
          a_d         = 1'b0;
          b_d         = 1'b0;
          busy_d      = 1'b1;
          pass_d      = 1'b0;
          fail_vec_d  = 4'd0;
          err_count_d = 3'd0;
        end
      end

      S_SETTLE: begin
        if (cnt_q < SETTLE_LAST) begin
          cnt_d = cnt_q + 4'd1;
        end else begin
          // Case inequality so an X/Z from the gate is a failure.
          mismatch               = (bus.gate_out !== EXPECT[idx_q]);
          fail_vec_d[idx_q]      = fail_vec_q[idx_q] | mismatch;
          err_count_d            = err_count_q + {2'b00, mismatch};
          if (idx_q != 2'd3) begin
            idx_d = idx_q + 2'd1;
            {a_d, b_d} = idx_q + 2'd1;
            cnt_d = 4'd0;
          end else begin
            state_d = S_DONE;
            busy_d  = 1'b0;
            a_d     = 1'b0;
            b_d     = 1'b0;
            done_d  = 1'b1;
            pass_d  = (err_count_q == 3'd0) && !mismatch;
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
        done_d  = 1'b0;
      end

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        a_d     = 1'b0;
        b_d     = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      idx_q       <= 2'd0;
      cnt_q       <= 4'd0;
      a_q         <= 1'b0;
      b_q         <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      fail_vec_q  <= 4'd0;
      err_count_q <= 3'd0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      a_q         <= a_d;
      b_q         <= b_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      fail_vec_q  <= fail_vec_d;
      err_count_q <= err_count_d;
    end
  end

  assign bus.a         = a_q;
  assign bus.b         = b_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.pass      = pass_q;
  assign bus.fail_vec  = fail_vec_q;
  assign bus.err_count = err_count_q;

endmodule

`default_nettype wire

// File: tb/tb_gate2_tester.sv
// ============================================================
// tb_gate2_tester: scoreboard bench for gate2_tester with AND,
// stuck-at, OR, NAND and delayed-NAND gate models.
// Rev 1.0
// ============================================================
`default_nettype none

module tb_gate2_tester;

  typedef struct packed {
    logic       pass;
    logic [3:0] fail_vec;
    logic [2:0] err_count;
  } result_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  gate2_tester_if if0 ();
  gate2_tester_if if1 ();

  gate2_tester u_and (
    .clk (clk),
    .rst (rst),
    .bus (if0.master)
  );

  gate2_tester #(.SETTLE_CYCLES(0), .EXPECT(4'b0111)) u_nand (
    .clk (clk),
    .rst (rst),
    .bus (if1.master)
  );

  // Gate models: 0 = ideal, 1 = fault/delayed variant, 2 = OR
  logic [1:0] mode0 = 2'd0;
  logic [1:0] mode1 = 2'd0;
  logic       dly_q;
  logic       start_r [2];

  // Delay register only advances during a run, so right after reset the
  // first sample sees its reset value of 0.
  always @(posedge clk or posedge rst) begin
    if (rst) dly_q <= 1'b0;
    else if (if1.busy) dly_q <= ~(if1.a & if1.b);
  end

  assign if0.gate_out = (mode0 == 2'd0) ? (if0.a & if0.b) :
                        (mode0 == 2'd1) ? 1'b0 : (if0.a | if0.b);
  assign if1.gate_out = (mode1 == 2'd1) ? dly_q : ~(if1.a & if1.b);
  assign if0.start    = start_r[0];
  assign if1.start    = start_r[1];

  logic [1:0] ab_w   [2];
  logic       busy_w [2];
  logic       done_w [2];
  result_t    res_w  [2];

  assign ab_w[0]   = {if0.a, if0.b};
  assign ab_w[1]   = {if1.a, if1.b};
  assign busy_w[0] = if0.busy;
  assign busy_w[1] = if1.busy;
  assign done_w[0] = if0.done;
  assign done_w[1] = if1.done;
  assign res_w[0]  = {if0.pass, if0.fail_vec, if0.err_count};
  assign res_w[1]  = {if1.pass, if1.fail_vec, if1.err_count};

  int n_checks = 0;
  int n_pass   = 0;
  result_t exp_q0 [$];
  result_t exp_q1 [$];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp)
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    else
      n_pass++;
  endtask

  task automatic push_exp(input int inst, input logic [3:0] fv, input logic [2:0] ec);
    result_t r;
    r = '{pass: (fv == 4'd0), fail_vec: fv, err_count: ec};
    if (inst == 0) exp_q0.push_back(r);
    else           exp_q1.push_back(r);
  endtask

  // Monitors: pop an expected result whenever a done pulse appears.
  task automatic score(input int inst, input result_t act, input int pending);
    result_t e;
    check($sformatf("sb%0d_pending", inst), 8'(pending != 0), 8'd1);
    if (pending != 0) begin
      if (inst == 0) e = exp_q0.pop_front();
      else           e = exp_q1.pop_front();
      check($sformatf("sb%0d_pass", inst),      8'(act.pass),      8'(e.pass));
      check($sformatf("sb%0d_fail_vec", inst),  8'(act.fail_vec),  8'(e.fail_vec));
      check($sformatf("sb%0d_err_count", inst), 8'(act.err_count), 8'(e.err_count));
    end
  endtask

  always @(negedge clk) if (done_w[0]) score(0, res_w[0], exp_q0.size());
  always @(negedge clk) if (done_w[1]) score(1, res_w[1], exp_q1.size());

  // One run: start sampled at E0, vector/busy/done timing checked every cycle.
  task automatic run(input int inst, input int s, input logic [3:0] fv,
                     input logic [2:0] ec, input bit hold);
    int per;
    per = s + 1;
    @(negedge clk);
    push_exp(inst, fv, ec);
    start_r[inst] = 1'b1;
    @(posedge clk);
    for (int j = 0; j < 4 * per; j++) begin
      @(negedge clk);
      if (!hold) start_r[inst] = 1'b0;
      check("vec_ab",   8'(ab_w[inst]),   8'(j / per));
      check("vec_busy", 8'(busy_w[inst]), 8'd1);
      check("vec_done", 8'(done_w[inst]), 8'd0);
    end
    @(negedge clk);
    check("end_done", 8'(done_w[inst]), 8'd1);
    check("end_busy", 8'(busy_w[inst]), 8'd0);
    check("end_ab",   8'(ab_w[inst]),   8'd0);
    @(negedge clk);
    check("post_done", 8'(done_w[inst]), 8'd0);
    check("post_busy", 8'(busy_w[inst]), 8'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    start_r[0] = 1'b0;
    start_r[1] = 1'b0;
    #12;
    check("rst_ab",   8'(ab_w[0]),   8'd0);
    check("rst_busy", 8'(busy_w[0]), 8'd0);
    check("rst_done", 8'(done_w[0]), 8'd0);
    check("rst_res",  8'(res_w[0]),  8'd0);
    @(negedge clk);
    rst = 1'b0;

    mode0 = 2'd0; run(0, 2, 4'b0000, 3'd0, 1'b0);
    mode0 = 2'd1; run(0, 2, 4'b1000, 3'd1, 1'b0);
    mode0 = 2'd2; run(0, 2, 4'b0110, 3'd2, 1'b0);
    repeat (5) @(negedge clk);
    check("held_res", 8'(res_w[0]), 8'({1'b0, 4'b0110, 3'd2}));

    // Continuous start: exactly one run, then a second accepted at E0+4(S+1)+2.
    mode0 = 2'd0;
    run(0, 2, 4'b0000, 3'd0, 1'b1);
    push_exp(0, 4'b0000, 3'd0);
    @(negedge clk);
    check("rerun_busy", 8'(busy_w[0]), 8'd1);
    check("rerun_clr",  8'(res_w[0]),  8'd0);
    start_r[0] = 1'b0;
    begin
      int k;
      k = 0;
      while (!done_w[0] && k < 40) begin
        @(negedge clk);
        k++;
      end
      check("rerun_done_seen", 8'(done_w[0]), 8'd1);
    end
    @(negedge clk);

    mode1 = 2'd0; run(1, 0, 4'b0000, 3'd0, 1'b0);

    // Delayed NAND straight after reset: vector 0 sees the reset value 0,
    // and vector 3 sees the previous vector's NAND (1) instead of 0.
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    mode1 = 2'd1; run(1, 0, 4'b1001, 3'd2, 1'b0);

    // Mid-run asynchronous reset while idx=2.
    mode0 = 2'd0;
    @(negedge clk);
    start_r[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_r[0] = 1'b0;
    repeat (6) @(negedge clk);
    check("mid_ab_idx2", 8'(ab_w[0]), 8'd2);
    #2 rst = 1'b1;
    #1;
    check("arst_ab",   8'(ab_w[0]),   8'd0);
    check("arst_busy", 8'(busy_w[0]), 8'd0);
    check("arst_res",  8'(res_w[0]),  8'd0);
    @(negedge clk); rst = 1'b0;
    run(0, 2, 4'b0000, 3'd0, 1'b0);

    repeat (3) @(negedge clk);
    check("sb0_drained", 8'(exp_q0.size()), 8'd0);
    check("sb1_drained", 8'(exp_q1.size()), 8'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
